// File: rtl/dab_pkg.sv
// Shared definitions for the DAB gate driver: bridge voltage level codes,
// per-leg dead-time FSM state encoding, and default dead-time counter width.
// No logic; types and constants only.
package dab_pkg;

  // Two-bit signed bridge voltage command levels
  localparam logic [1:0] V_POS  = 2'b01;
  localparam logic [1:0] V_ZERO = 2'b00;
  localparam logic [1:0] V_NEG  = 2'b11;
  // -2 is not a legal three-level command; seeing it latches a fault
  localparam logic [1:0] V_ILL  = 2'b10;

  localparam int DT_W_DEF = 8;

  typedef enum logic [1:0] {
    LEG_OFF   = 2'b00,
    LEG_LO_ON = 2'b01,
    LEG_HI_ON = 2'b10,
    LEG_DEAD  = 2'b11
  } leg_state_t;

endpackage

// File: rtl/dab_leg_deadtime.sv
// Purpose: one half-bridge leg; drives hi/lo gates from a target level with a dead gap on every switch.
// Latency: a target change moves the conducting gate off on the next edge; the opposite gate
//          comes on max(deadtime, DT_MIN) edges later. No backpressure; runs every cycle.
// Ports: clk, rst (sync, active-high), target (1 = high switch), enable, deadtime -> hi, lo.
module dab_leg_deadtime
  import dab_pkg::*;
#(
  parameter int DT_W   = DT_W_DEF,
  parameter int DT_MIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            target,
  input  logic            enable,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  leg_state_t      state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic [DT_W-1:0] dt_eff;

  // A programmed dead time below the floor is raised to the floor
  assign dt_eff = (deadtime < DT_W'(DT_MIN)) ? DT_W'(DT_MIN) : deadtime;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEG_OFF;
      cnt_q   <= '0;
      dt_q    <= DT_W'(DT_MIN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dt_q    <= dt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dt_d    = dt_q;
    unique case (state_q)
      LEG_OFF: begin
        if (enable) begin
          state_d = LEG_DEAD;
          cnt_d   = '0;
          dt_d    = dt_eff;
        end
      end
      LEG_LO_ON: begin
        if (target) begin
          state_d = LEG_DEAD;
          cnt_d   = '0;
          dt_d    = dt_eff;
        end
      end
      LEG_HI_ON: begin
        if (!target) begin
          state_d = LEG_DEAD;
          cnt_d   = '0;
          dt_d    = dt_eff;
        end
      end
      LEG_DEAD: begin
        // Full interval is always served; the side chosen is the target at expiry,
        // so a command that reverts mid-gap simply returns to the original switch.
        if (cnt_q == dt_q - DT_W'(1)) begin
          state_d = target ? LEG_HI_ON : LEG_LO_ON;
        end else begin
          cnt_d = cnt_q + DT_W'(1);
        end
      end
      default: state_d = LEG_OFF;
    endcase
    // Disable overrides everything in the same cycle
    if (!enable) begin
      state_d = LEG_OFF;
      cnt_d   = '0;
    end
  end

  // Gates decode straight from the state register: never both on, glitch-free
  assign hi = (state_q == LEG_HI_ON);
  assign lo = (state_q == LEG_LO_ON);

endmodule

// File: rtl/dab_gate_driver.sv
// Purpose: turns DAB bridge voltage commands V1/V2 into 8 gate signals with dead time and fault blanking.
// Latency: inputs registered once; gates respond one edge later, plus D on any turn-on.
// Backpressure: none; commands are sampled every cycle.
// Ports: clk, rst (sync, active-high), en, V1, V2, deadtime -> Sp[3:0], Ss[3:0], fault (sticky).
//        Sp/Ss bits: [0] leg A high, [1] leg A low, [2] leg B high, [3] leg B low.
module dab_gate_driver
  import dab_pkg::*;
#(
  parameter int DT_W   = DT_W_DEF,
  parameter int DT_MIN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [1:0]      V1,
  input  logic [1:0]      V2,
  input  logic [DT_W-1:0] deadtime,
  output logic [3:0]      Sp,
  output logic [3:0]      Ss,
  output logic            fault
);

  logic            en_r;
  logic [1:0]      v1_r, v2_r;
  logic [DT_W-1:0] dt_r;
  logic            illegal;
  logic            leg_en;
  logic            pa_hi, pa_lo, pb_hi, pb_lo;
  logic            sa_hi, sa_lo, sb_hi, sb_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_r  <= 1'b0;
      v1_r  <= V_ZERO;
      v2_r  <= V_ZERO;
      dt_r  <= '0;
      fault <= 1'b0;
    end else begin
      en_r  <= en;
      v1_r  <= V1;
      v2_r  <= V2;
      dt_r  <= deadtime;
      fault <= fault | illegal;
    end
  end

  assign illegal = (v1_r == V_ILL) || (v2_r == V_ILL);
  // Illegal code blanks the legs on the same edge that sets fault, not one later
  assign leg_en  = en_r && !fault && !illegal;

  // Leg A conducts high only for +1, leg B only for -1; 0 leaves both low
  dab_leg_deadtime #(.DT_W(DT_W), .DT_MIN(DT_MIN)) u_pa (
    .clk(clk), .rst(rst), .target(v1_r == V_POS), .enable(leg_en),
    .deadtime(dt_r), .hi(pa_hi), .lo(pa_lo)
  );
  dab_leg_deadtime #(.DT_W(DT_W), .DT_MIN(DT_MIN)) u_pb (
    .clk(clk), .rst(rst), .target(v1_r == V_NEG), .enable(leg_en),
    .deadtime(dt_r), .hi(pb_hi), .lo(pb_lo)
  );
  dab_leg_deadtime #(.DT_W(DT_W), .DT_MIN(DT_MIN)) u_sa (
    .clk(clk), .rst(rst), .target(v2_r == V_POS), .enable(leg_en),
    .deadtime(dt_r), .hi(sa_hi), .lo(sa_lo)
  );
  dab_leg_deadtime #(.DT_W(DT_W), .DT_MIN(DT_MIN)) u_sb (
    .clk(clk), .rst(rst), .target(v2_r == V_NEG), .enable(leg_en),
    .deadtime(dt_r), .hi(sb_hi), .lo(sb_lo)
  );

  assign Sp = {pb_lo, pb_hi, pa_lo, pa_hi};
  assign Ss = {sb_lo, sb_hi, sa_lo, sa_hi};

endmodule

// File: tb/tb_dab_gate_driver.sv
// Bench for dab_gate_driver: directed sequences then randomized commands.
// A time-based reference model predicts gates/fault after every edge into a queue;
// a negedge monitor pops and compares, and also checks for shoot-through.
module tb_dab_gate_driver;

  localparam int DT_W   = 8;
  localparam int DT_MIN = 1;

  logic            clk;
  logic            rst;
  logic            en;
  logic [1:0]      v1, v2;
  logic [DT_W-1:0] dt;
  logic [3:0]      Sp, Ss;
  logic            fault;

  typedef struct packed {
    logic [3:0] sp;
    logic [3:0] ss;
    logic       f;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  dab_gate_driver #(.DT_W(DT_W), .DT_MIN(DT_MIN)) dut (
    .clk(clk), .rst(rst), .en(en), .V1(v1), .V2(v2), .deadtime(dt),
    .Sp(Sp), .Ss(Ss), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Each leg is either conducting (side 1 = low, 2 = high), off (0), or blanked
  // until an absolute cycle number, at which the side is taken from the target.
  logic            m_en, m_fault;
  logic [1:0]      m_v1, m_v2;
  logic [DT_W-1:0] m_dt;
  int              side[4];
  bit              blanking[4];
  int              blank_end[4];
  int              cyc = 0;

  function automatic bit tgt_of(int leg, logic [1:0] a, logic [1:0] b);
    logic [1:0] v;
    v = (leg < 2) ? a : b;
    return (leg % 2 == 0) ? (v == 2'b01) : (v == 2'b11);
  endfunction

  initial begin
    exp_t e;
    bit   ok, ill, tgt;
    int   d;
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (rst) begin
        for (int l = 0; l < 4; l++) begin
          side[l] = 0; blanking[l] = 0; blank_end[l] = 0;
        end
        m_fault = 1'b0;
      end else begin
        ill = (m_v1 == 2'b10) || (m_v2 == 2'b10);
        ok  = m_en && !m_fault && !ill;
        d   = (int'(m_dt) < DT_MIN) ? DT_MIN : int'(m_dt);
        for (int l = 0; l < 4; l++) begin
          tgt = tgt_of(l, m_v1, m_v2);
          if (!ok) begin
            side[l] = 0; blanking[l] = 0;
          end else if (blanking[l]) begin
            if (cyc == blank_end[l]) begin
              blanking[l] = 0;
              side[l] = tgt ? 2 : 1;
            end
          end else if (side[l] == 0 || ((side[l] == 2) != tgt)) begin
            side[l] = 0; blanking[l] = 1; blank_end[l] = cyc + d;
          end
        end
        m_fault = m_fault | ill;
        for (int l = 0; l < 4; l++) begin
          int b;
          b = (l % 2) * 2;
          if (l < 2) begin
            e.sp[b] = (side[l] == 2); e.sp[b+1] = (side[l] == 1);
          end else begin
            e.ss[b] = (side[l] == 2); e.ss[b+1] = (side[l] == 1);
          end
        end
        e.f = m_fault;
      end
      exp_q.push_back(e);
      // input register as seen after this edge
      if (rst) begin
        m_en = 1'b0; m_v1 = 2'b00; m_v2 = 2'b00; m_dt = '0;
      end else begin
        m_en = en; m_v1 = v1; m_v2 = v2; m_dt = dt;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    logic [3:0] shoot;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({Sp, Ss, fault} !== {e.sp, e.ss, e.f}) begin
          bad++;
          $display("FAIL gates cyc=%0d Sp=%b want %b Ss=%b want %b fault=%b want %b",
                   cyc, Sp, e.sp, Ss, e.ss, fault, e.f);
        end
        shoot = (Sp & {1'b0, Sp[3:1]} & 4'b0101) | (Ss & {1'b0, Ss[3:1]} & 4'b0101);
        total++;
        if (shoot !== 4'b0000) begin
          bad++;
          $display("FAIL shoot_through cyc=%0d Sp=%b Ss=%b want no leg with both on", cyc, Sp, Ss);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] rand_v(input bit allow_ill);
    int r;
    r = $urandom_range(0, 99);
    if (allow_ill && r < 2) return 2'b10;
    case (r % 3)
      0:       return 2'b00;
      1:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; v1 = 2'b00; v2 = 2'b00; dt = 8'd5;
    wait_cyc(2);
    rst = 1'b0; en = 1'b1;
    wait_cyc(12);                          // power-up: Sp -> 1010 after the dead gap
    v1 = 2'b01; wait_cyc(10);              // 0 -> +1 on leg A
    v1 = 2'b00; wait_cyc(10);              // +1 -> 0
    v1 = 2'b11; wait_cyc(10);              // 0 -> -1 on leg B
    dt = 8'd0; v1 = 2'b00; wait_cyc(5);    // minimum one-cycle gap
    v1 = 2'b01; wait_cyc(5);
    dt = 8'd10; v1 = 2'b00; wait_cyc(3);   // gap latched at 10 ...
    dt = 8'd2; wait_cyc(12);               // ... change to 2 mid-gap
    v1 = 2'b01; wait_cyc(6);               // next gap uses 2
    dt = 8'd8; v2 = 2'b01; wait_cyc(15);
    v2 = 2'b00; wait_cyc(2);               // short excursion: no S2 glitch
    v2 = 2'b01; wait_cyc(15);
    v1 = 2'b11; v2 = 2'b11; wait_cyc(12);  // both bridges together
    en = 1'b0; wait_cyc(3);                // disable blanks all
    en = 1'b1; wait_cyc(12);
    v1 = 2'b10; wait_cyc(1);               // illegal code for one cycle
    v1 = 2'b01; wait_cyc(10);              // fault stays, gates stay off
    rst = 1'b1; wait_cyc(1);
    rst = 1'b0; wait_cyc(12);

    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 39) begin
        rst = 1'b1; wait_cyc(1); rst = 1'b0;
      end
      v1 = rand_v(1'b1);
      v2 = rand_v(1'b1);
      en = ($urandom_range(0, 19) != 0);
      dt = DT_W'($urandom_range(0, 12));
      wait_cyc($urandom_range(1, 15));
    end

    wait_cyc(2);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
